// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for serial sequence detectors: valid/ready word in, one bit per clk out with sof/eof.
// Optional even-parity bit after the data bits when SEQ_SERIALIZER_PARITY_EN is defined.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH);
  localparam logic [3:0]    GAP_LAST = 4'(GAP);
`ifndef SEQ_SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] LAST_M1  = CW'(WIDTH - 1);
`endif

`ifdef SEQ_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, sr_shl, din_shl;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       gcnt, gcnt_n;
  logic             x_n, xv_n, sof_n, eof_n, busy_n;
  logic             sr_bit, din_bit, load, done;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif

  // Head bit and shifted remainder for both the held word and the incoming word.
  assign sr_bit  = (MSB_FIRST != 0) ? sr[WIDTH-1]  : sr[0];
  assign din_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
  assign sr_shl  = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0}  : {1'b0, sr[WIDTH-1:1]};
  assign din_shl = (MSB_FIRST != 0) ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};

  // done: the last serial bit of the frame is on x this cycle.
`ifdef SEQ_SERIALIZER_PARITY_EN
  assign done = (state == S_PAR);
`else
  assign done = (state == S_SHIFT) && (cnt == LAST);
`endif

  assign din_ready = rst_n && ((state == S_IDLE) || ((GAP == 0) && done));
  assign load      = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sr      <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      sof     <= 1'b0;
      eof     <= 1'b0;
      busy    <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      gcnt    <= gcnt_n;
      x       <= x_n;
      x_valid <= xv_n;
      sof     <= sof_n;
      eof     <= eof_n;
      busy    <= busy_n;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    x_n     = 1'b0;
    xv_n    = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    busy_n  = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
    par_n   = par;
`endif
    case (state)
      S_SHIFT: begin
        if (cnt != LAST) begin
          x_n    = sr_bit;
          xv_n   = 1'b1;
          busy_n = 1'b1;
          sr_n   = sr_shl;
          cnt_n  = cnt + CW'(1);
`ifndef SEQ_SERIALIZER_PARITY_EN
          eof_n  = (cnt == LAST_M1);
`endif
        end
`ifdef SEQ_SERIALIZER_PARITY_EN
        else begin
          state_n = S_PAR;
          x_n     = par;
          xv_n    = 1'b1;
          busy_n  = 1'b1;
          eof_n   = 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) begin
          state_n = S_IDLE;
        end else begin
          gcnt_n = gcnt + 4'd1;
          busy_n = 1'b1;
        end
      end
      default: ;
    endcase

    if (done) begin
      if (GAP > 0) begin
        state_n = S_GAP;
        gcnt_n  = 4'd1;
        busy_n  = 1'b1;
      end else begin
        state_n = S_IDLE;
      end
    end

    // A transfer overrides everything; with GAP=0 it can land on the final bit for a bubble-free frame.
    if (load) begin
      state_n = S_SHIFT;
      x_n     = din_bit;
      xv_n    = 1'b1;
      sof_n   = 1'b1;
      busy_n  = 1'b1;
      sr_n    = din_shl;
      cnt_n   = CW'(1);
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_n   = ^din;
`endif
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: an MSB-first GAP=0 instance and an LSB-first GAP=2 instance.
module tb_seq_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din_a = '0, din_b = '0;
  logic       dv_a = 1'b0, dv_b = 1'b0;
  logic       rdy_a, x_a, xv_a, sof_a, eof_a, busy_a;
  logic       rdy_b, x_b, xv_b, sof_b, eof_b, busy_b;

  int total = 0;
  int bad   = 0;
  logic [2:0] qa[$];
  logic [2:0] qb[$];
  bit  mon_en = 1'b0;
  int  run_a = 0, max_a = 0;
  bit  gw = 1'b0;
  int  gc = 0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
    .x(x_a), .x_valid(xv_a), .sof(sof_a), .eof(eof_a), .busy(busy_a));

  seq_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(2)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
    .x(x_b), .x_valid(xv_b), .sof(sof_b), .eof(eof_b), .busy(busy_b));

  // s holds the hand-written transmission order, first bit in s[7].
  task automatic push_exp(input int which, input logic [7:0] w, input logic [7:0] s);
    logic [2:0] e;
    for (int i = 0; i < 8; i++) begin
      e = {s[7-i], (i == 0), (i == 7) && !PAR_EN};
      if (which == 0) qa.push_back(e); else qb.push_back(e);
    end
    if (PAR_EN) begin
      e = {^w, 1'b0, 1'b1};
      if (which == 0) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  task automatic send(input int which, input logic [7:0] w, input logic [7:0] s, input bit keep);
    bit got;
    int n;
    if (which == 0) begin din_a = w; dv_a = 1'b1; end
    else begin din_b = w; dv_b = 1'b1; end
    n = 0;
    do begin
      got = (which == 0) ? rdy_a : rdy_b;
      @(posedge clk); #1;
      n++;
    end while (!got && n < 200);
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout dut=%0d word=%h ready never seen", which, w);
    end else begin
      push_exp(which, w, s);
      @(negedge clk);
      total++;
      if (((which == 0) ? sof_a : sof_b) !== 1'b1) begin
        bad++;
        $display("FAIL first_bit_sof dut=%0d got=%b want=1", which, (which == 0) ? sof_a : sof_b);
      end
    end
    if (!keep) begin
      if (which == 0) dv_a = 1'b0; else dv_b = 1'b0;
    end
  endtask

  // Wait until the scoreboard empties, then the following cycle must be idle.
  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 0) ? qa.size() : qb.size()) != 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain_timeout dut=%0d left=%0d", which, (which == 0) ? qa.size() : qb.size());
    end
    @(negedge clk);
    total++;
    if (((which == 0) ? {xv_a, x_a} : {xv_b, x_b}) !== 2'b00) begin
      bad++;
      $display("FAIL after_eof_idle dut=%0d got xv,x=%b want 00", which, (which == 0) ? {xv_a, x_a} : {xv_b, x_b});
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (mon_en) begin
      total++;
      if (xv_a) begin
        run_a++;
        if (run_a > max_a) max_a = run_a;
        if (qa.size() == 0) begin
          bad++; $display("FAIL a_unexpected_bit got x,sof,eof=%b want none", {x_a, sof_a, eof_a});
        end else begin
          e = qa.pop_front();
          if ({x_a, sof_a, eof_a} !== e) begin
            bad++; $display("FAIL a_bit got x,sof,eof=%b want %b", {x_a, sof_a, eof_a}, e);
          end
        end
      end else begin
        run_a = 0;
        if ({x_a, sof_a, eof_a} !== 3'b000) begin
          bad++; $display("FAIL a_idle got x,sof,eof=%b want 000", {x_a, sof_a, eof_a});
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (mon_en) begin
      total++;
      if (xv_b) begin
        if (qb.size() == 0) begin
          bad++; $display("FAIL b_unexpected_bit got x,sof,eof=%b want none", {x_b, sof_b, eof_b});
        end else begin
          e = qb.pop_front();
          if ({x_b, sof_b, eof_b} !== e) begin
            bad++; $display("FAIL b_bit got x,sof,eof=%b want %b", {x_b, sof_b, eof_b}, e);
          end
        end
      end else if ({x_b, sof_b, eof_b} !== 3'b000) begin
        bad++; $display("FAIL b_idle got x,sof,eof=%b want 000", {x_b, sof_b, eof_b});
      end
      // Gap watch: two busy idle cycles after eof with ready low, then one IDLE cycle with ready high.
      if (gw) begin
        if (busy_b && !xv_b) begin
          gc++;
          total++;
          if (rdy_b !== 1'b0) begin bad++; $display("FAIL gap_ready got=%b want 0", rdy_b); end
        end else begin
          gw = 1'b0;
          total += 2;
          if (gc != 2) begin bad++; $display("FAIL gap_len got=%0d want 2", gc); end
          if ({busy_b, rdy_b} !== 2'b01) begin
            bad++; $display("FAIL gap_idle got busy,ready=%b want 01", {busy_b, rdy_b});
          end
        end
      end
      if (xv_b && eof_b) begin gw = 1'b1; gc = 0; end
    end
  end

  initial begin
    // Reset with din_valid high must not transfer.
    dv_a = 1'b1; din_a = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 2;
    if ({xv_a, x_a, sof_a, eof_a, busy_a, rdy_a} !== 6'b0) begin
      bad++; $display("FAIL reset_a got xv,x,sof,eof,busy,ready=%b want 000000", {xv_a, x_a, sof_a, eof_a, busy_a, rdy_a});
    end
    if ({xv_b, x_b, sof_b, eof_b, busy_b, rdy_b} !== 6'b0) begin
      bad++; $display("FAIL reset_b got xv,x,sof,eof,busy,ready=%b want 000000", {xv_b, x_b, sof_b, eof_b, busy_b, rdy_b});
    end
    dv_a = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rdy_a, rdy_b} !== 2'b11) begin
      bad++; $display("FAIL ready_after_release got=%b want 11", {rdy_a, rdy_b});
    end
    @(negedge clk);

    // Single word MSB-first, then LSB-first with GAP=2 back-to-back request.
    send(0, 8'b10101100, 8'b10101100, 1'b0);
    drain(0);
    send(1, 8'b10101100, 8'b00110101, 1'b1);
    send(1, 8'h3C, 8'b00111100, 1'b0);
    drain(1);
    repeat (4) @(negedge clk);

    // Back-to-back with din_valid held: frames must be contiguous.
    max_a = 0;
    send(0, 8'hA5, 8'hA5, 1'b1);
    send(0, 8'h3C, 8'h3C, 1'b0);
    drain(0);
    total++;
    if (max_a != (PAR_EN ? 18 : 16)) begin
      bad++; $display("FAIL b2b_run got=%0d want %0d", max_a, PAR_EN ? 18 : 16);
    end

    // Odd-weight word (parity bit 1 when parity is built in).
    send(0, 8'b10101101, 8'b10101101, 1'b0);
    drain(0);

    // Reset after 3 bits of 8'hFF; remaining bits must vanish.
    send(0, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    qa.delete();
    @(negedge clk);
    total++;
    if ({xv_a, busy_a, rdy_a} !== 3'b000) begin
      bad++; $display("FAIL midframe_reset got xv,busy,ready=%b want 000", {xv_a, busy_a, rdy_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'h81, 8'b10000001, 1'b0);
    drain(0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the serial sequence-detector FSMs (divisibility checkers and similar). Accepts a WIDTH-bit word over a valid/ready handshake and presents it on a single-bit `x` line, one bit per `clk` cycle, with frame markers. It sits directly upstream of a detector and drives its `x` input.

## Interface
Parameters:
- `WIDTH`, 8: data word width; legal range 2..32.
- `MSB_FIRST`, 1: 1 = `din[WIDTH-1]` shifted first; 0 = `din[0]` first.
- `GAP`, 0: idle cycles inserted after each frame; legal range 0..15.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial data bit to the downstream detector.
- `x_valid`  out  1  `x` carries a frame bit this cycle.
- `sof`  out  1  first bit of a frame.
- `eof`  out  1  last bit of a frame.
- `busy`  out  1  a frame is in progress, or a gap is being inserted.

## Operation
- FSM states: IDLE, SHIFT, PAR (only with the parity macro), GAP.
- Transfer: a word transfers on a rising edge when `din_valid && din_ready`. The word is captured into a shift register, and a bit counter is loaded.
- IDLE
  - `din_ready`=1.
  - On transfer, go to SHIFT.
- SHIFT
  - Emits one bit per cycle in the order set by `MSB_FIRST`.
  - After bit WIDTH: go to PAR if parity is enabled; else go to GAP if `GAP`>0; else go to IDLE.
- PAR: emits a single parity bit, then follows the same GAP/IDLE rule.
- GAP: counts `GAP` cycles with `x_valid`=0, then returns to IDLE.
- Back-to-back frames (`GAP`=0 only):
  - `din_ready` is also 1 during the final serial cycle of a frame.
  - A transfer on that edge goes straight to SHIFT, so the next frame's first bit follows with no bubble.
- `din_ready` is 0 in all other cycles of SHIFT/PAR/GAP, and 0 while `rst_n`=0.
- `x` is 0 whenever `x_valid`=0. The downstream detector samples `x` every cycle, so idle cycles present zeros.
- `busy`=1 in SHIFT, PAR and GAP.
- Changes to `din` after a transfer have no effect on the frame in flight.
- Reset mid-frame:
  - On the reset edge, state returns to IDLE and the partial word is discarded.
  - All outputs are 0 on the next cycle.
  - No residual bits are emitted after reset releases.

## Timing
- Reset values (after a `clk` edge with `rst_n`=0):
  - `x`=0, `x_valid`=0, `sof`=0, `eof`=0, `busy`=0.
  - `din_ready`=0 while `rst_n` is low; 1 on the first cycle after release.
- `x`, `x_valid`, `sof`, `eof` and `busy` are registered. `din_ready` is combinational from state and `rst_n`.
- Transfer at edge k:
  - The first bit is valid in the cycle after edge k, with `sof`=1.
  - Bit i is valid in the cycle after edge k+i-1.
  - `eof` is asserted with the last bit: bit WIDTH, or the parity bit.
- Frame length:
  - WIDTH cycles, or WIDTH+1 with parity.
  - Frame period is frame length + `GAP` cycles, plus at least 1 IDLE cycle when `GAP`>0.
- `sof` and `eof` are each high exactly 1 cycle per frame. They are never both high, since WIDTH≥2.

## Configuration
- Macro: `SEQ_SERIALIZER_PARITY_EN`.
- Defined:
  - PAR state is compiled in.
  - After the data bits, one even-parity bit is emitted: XOR of all WIDTH data bits.
  - `eof` is on the parity bit; frame length is WIDTH+1.
- Undefined:
  - No PAR state, no parity logic.
  - `eof` is on data bit WIDTH; frame length is WIDTH.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `din_valid`=1 → no transfer; all outputs 0 and `din_ready`=0; `din_ready`=1 on the first cycle after release.
- Single word (WIDTH=8, `MSB_FIRST`=1, `din`=8'b10101100), transfer at edge k:
  - `x`=1,0,1,0,1,1,0,0 over cycles k+1..k+8, with `x_valid`=1 throughout.
  - `sof` at k+1, `eof` at k+8; `x_valid`=0 and `x`=0 at k+9.
- `MSB_FIRST`=0, `din`=8'b10101100 → `x`=0,0,1,1,0,1,0,1.
- Back-to-back (`GAP`=0): `din_valid` held high with words 8'hA5 then 8'h3C:
  - 16 contiguous valid bits; the second transfer occurs on the first word's `eof` cycle.
  - `sof` appears exactly at bits 1 and 9.
- Gap (`GAP`=2): two words →
  - exactly 2 cycles with `busy`=1 and `x_valid`=0 after `eof`, then 1 IDLE cycle with `din_ready`=1;
  - `din_ready`=0 during the gap.
- Mid-frame reset: assert `rst_n`=0 after 3 bits of 8'hFF →
  - `x_valid`=0 from the next cycle;
  - after release, 8'h81 serializes as 1,0,0,0,0,0,0,1 with no leftover bits of 8'hFF.
- With `SEQ_SERIALIZER_PARITY_EN`:
  - 8'b10101100 → 9th bit 0, `eof` on bit 9.
  - 8'b10101101 → 9th bit 1.
